// File: rtl/hssim_pkg.sv
// Shared constants and FSM encoding for the HSSIM pooling block.
package hssim_pkg;

  localparam int unsigned FRAC_DEF   = 12;
  localparam int unsigned HCNT_W_DEF = 20;
  localparam int unsigned ONE        = 1 << FRAC_DEF;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } pool_state_e;

endpackage

// File: rtl/hssim_pool_if.sv
// HSSIM numerator/denominator input stream plus per-pixel and per-frame SSIM results.
interface hssim_pool_if #(
  parameter int unsigned FRAC   = hssim_pkg::FRAC_DEF,
  parameter int unsigned HCNT_W = hssim_pkg::HCNT_W_DEF
) ();

  logic                     hin_valid;
  logic signed [34:0]       hin_numr;
  logic signed [30:0]       hin_deno;
  logic                     hin_frame_end;
  logic                     hpix_valid;
  logic signed [FRAC+1:0]   hpix_ssim;
  logic                     hpix_bad;
  logic                     hframe_done;
  logic signed [FRAC+1:0]   hframe_ssim;
  logic [HCNT_W-1:0]        hframe_count;
  logic                     hoverrun;

  modport master (
    output hin_valid, hin_numr, hin_deno, hin_frame_end,
    input  hpix_valid, hpix_ssim, hpix_bad,
    input  hframe_done, hframe_ssim, hframe_count, hoverrun
  );

  modport slave (
    input  hin_valid, hin_numr, hin_deno, hin_frame_end,
    output hpix_valid, hpix_ssim, hpix_bad,
    output hframe_done, hframe_ssim, hframe_count, hoverrun
  );

endinterface

// File: rtl/hdiv_pipe.sv
// Fully pipelined per-pixel divider: FRAC+2 register stages, one quotient bit per stage,
// result in signed Q1.FRAC truncated toward zero, saturated to +/-1.0, forced 0 on bad deno.
module hdiv_pipe #(
  parameter int unsigned FRAC = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [34:0]     in_numr,
  input  logic signed [30:0]     in_deno,
  input  logic                   in_fend,
  output logic                   out_valid,
  output logic signed [FRAC+1:0] out_ssim,
  output logic                   out_bad,
  output logic                   out_fend
);

  localparam int unsigned REM_W = 31;
  localparam logic [FRAC+1:0] ONE_S = {2'b01, {FRAC{1'b0}}};

  logic [REM_W-1:0] rem_q  [0:FRAC];
  logic [REM_W-1:0] rem_d  [0:FRAC];
  logic [30:0]      deno_q [0:FRAC];
  logic [30:0]      deno_d [0:FRAC];
  logic [FRAC-1:0]  quo_q  [0:FRAC];
  logic [FRAC-1:0]  quo_d  [0:FRAC];
  logic             vld_q  [0:FRAC];
  logic             vld_d  [0:FRAC];
  logic             fend_q [0:FRAC];
  logic             fend_d [0:FRAC];
  logic             sign_q [0:FRAC];
  logic             sign_d [0:FRAC];
  logic             bad_q  [0:FRAC];
  logic             bad_d  [0:FRAC];
  logic             sat_q  [0:FRAC];
  logic             sat_d  [0:FRAC];

  logic                   out_valid_q, out_valid_d;
  logic                   out_bad_q, out_bad_d;
  logic                   out_fend_q, out_fend_d;
  logic signed [FRAC+1:0] out_ssim_q, out_ssim_d;

  logic [34:0]      abs_numr;
  logic [REM_W:0]   r2;
  logic             ge;
  logic [FRAC+1:0]  mag;

  always_comb begin
    abs_numr  = in_numr[34] ? 35'(-in_numr) : 35'(in_numr);
    vld_d[0]  = in_valid;
    fend_d[0] = in_fend;
    sign_d[0] = in_numr[34];
    deno_d[0] = in_deno;
    bad_d[0]  = in_deno[30] || (in_deno == '0);
    sat_d[0]  = abs_numr >= {4'b0000, in_deno};
    // Only non-saturated lanes need the remainder, and those have |numr| < deno < 2^30.
    rem_d[0]  = abs_numr[REM_W-1:0];
    quo_d[0]  = '0;
    r2        = '0;
    ge        = 1'b0;
    for (int unsigned k = 1; k <= FRAC; k++) begin
      r2        = {rem_q[k-1], 1'b0};
      ge        = r2 >= {1'b0, deno_q[k-1]};
      rem_d[k]  = ge ? REM_W'(r2 - {1'b0, deno_q[k-1]}) : r2[REM_W-1:0];
      quo_d[k]  = {quo_q[k-1][FRAC-2:0], ge};
      deno_d[k] = deno_q[k-1];
      vld_d[k]  = vld_q[k-1];
      fend_d[k] = fend_q[k-1];
      sign_d[k] = sign_q[k-1];
      bad_d[k]  = bad_q[k-1];
      sat_d[k]  = sat_q[k-1];
    end
    mag         = bad_q[FRAC] ? '0 : (sat_q[FRAC] ? ONE_S : {2'b00, quo_q[FRAC]});
    out_ssim_d  = sign_q[FRAC] ? -mag : mag;
    out_valid_d = vld_q[FRAC];
    out_bad_d   = bad_q[FRAC];
    out_fend_d  = fend_q[FRAC];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k <= FRAC; k++) begin
        rem_q[k]  <= '0;
        deno_q[k] <= '0;
        quo_q[k]  <= '0;
        vld_q[k]  <= 1'b0;
        fend_q[k] <= 1'b0;
        sign_q[k] <= 1'b0;
        bad_q[k]  <= 1'b0;
        sat_q[k]  <= 1'b0;
      end
      out_valid_q <= 1'b0;
      out_bad_q   <= 1'b0;
      out_fend_q  <= 1'b0;
      out_ssim_q  <= '0;
    end else begin
      for (int unsigned k = 0; k <= FRAC; k++) begin
        rem_q[k]  <= rem_d[k];
        deno_q[k] <= deno_d[k];
        quo_q[k]  <= quo_d[k];
        vld_q[k]  <= vld_d[k];
        fend_q[k] <= fend_d[k];
        sign_q[k] <= sign_d[k];
        bad_q[k]  <= bad_d[k];
        sat_q[k]  <= sat_d[k];
      end
      out_valid_q <= out_valid_d;
      out_bad_q   <= out_bad_d;
      out_fend_q  <= out_fend_d;
      out_ssim_q  <= out_ssim_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ssim  = out_ssim_q;
  assign out_bad   = out_bad_q;
  assign out_fend  = out_fend_q;

endmodule

// File: rtl/hssim_pool.sv
// Per-frame SSIM pooling: accumulates per-pixel SSIM and computes the frame mean with a
// bit-serial divider started on each frame-end pixel.
module hssim_pool
  import hssim_pkg::*;
#(
  parameter int unsigned FRAC   = FRAC_DEF,
  parameter int unsigned HCNT_W = HCNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  hssim_pool_if.slave bus
);

  localparam int unsigned SUMW = FRAC + HCNT_W + 2;
  localparam int unsigned CW   = $clog2(SUMW);
  localparam logic [SUMW-1:0] ONE_W = SUMW'(1) << FRAC;
  localparam logic [FRAC+1:0] ONE_S = {2'b01, {FRAC{1'b0}}};

  logic                   pix_valid, pix_bad, pix_fend;
  logic signed [FRAC+1:0] pix_ssim;

  hdiv_pipe #(.FRAC(FRAC)) u_hdiv_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.hin_valid),
    .in_numr   (bus.hin_numr),
    .in_deno   (bus.hin_deno),
    .in_fend   (bus.hin_frame_end),
    .out_valid (pix_valid),
    .out_ssim  (pix_ssim),
    .out_bad   (pix_bad),
    .out_fend  (pix_fend)
  );

  pool_state_e            state_q, state_d;
  logic signed [SUMW-1:0] sum_q, sum_d, sum_next;
  logic [HCNT_W-1:0]      cnt_q, cnt_d, cnt_next;
  logic [SUMW-1:0]        dvd_q, dvd_d, quo_q, quo_d, abs_sum;
  logic [HCNT_W-1:0]      rem_q, rem_d, dsor_q, dsor_d;
  logic [HCNT_W:0]        rem_sh;
  logic                   ge, capture;
  logic                   neg_q, neg_d;
  logic [CW-1:0]          dcnt_q, dcnt_d;
  logic [FRAC+1:0]        mag;
  logic                   done_q, done_d, ovr_q, ovr_d;
  logic signed [FRAC+1:0] fssim_q, fssim_d;
  logic [HCNT_W-1:0]      fcount_q, fcount_d;

  always_comb begin
    sum_next = sum_q + {{(SUMW-FRAC-2){pix_ssim[FRAC+1]}}, pix_ssim};
    cnt_next = (&cnt_q) ? cnt_q : cnt_q + HCNT_W'(1);
    capture  = pix_valid & pix_fend;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    // The accumulator clears on every frame end, even one dropped for overrun.
    if (pix_valid) begin
      if (pix_fend) begin
        sum_d = '0;
        cnt_d = '0;
      end else begin
        sum_d = sum_next;
        cnt_d = cnt_next;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsor_d   = dsor_q;
    neg_d    = neg_q;
    dcnt_d   = dcnt_q;
    done_d   = 1'b0;
    fssim_d  = fssim_q;
    fcount_d = fcount_q;
    ovr_d    = ovr_q | (capture && (state_q != IDLE));
    abs_sum  = sum_next[SUMW-1] ? SUMW'(-sum_next) : SUMW'(sum_next);
    rem_sh   = {rem_q, dvd_q[SUMW-1]};
    ge       = rem_sh >= {1'b0, dsor_q};
    mag      = (quo_q > ONE_W) ? ONE_S : quo_q[FRAC+1:0];
    case (state_q)
      IDLE: begin
        if (capture) begin
          dvd_d   = abs_sum;
          dsor_d  = cnt_next;
          neg_d   = sum_next[SUMW-1];
          rem_d   = '0;
          quo_d   = '0;
          dcnt_d  = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d  = ge ? HCNT_W'(rem_sh - {1'b0, dsor_q}) : rem_sh[HCNT_W-1:0];
        dvd_d  = {dvd_q[SUMW-2:0], 1'b0};
        quo_d  = {quo_q[SUMW-2:0], ge};
        dcnt_d = dcnt_q + CW'(1);
        if (dcnt_q == CW'(SUMW - 1)) state_d = DONE;
      end
      DONE: begin
        fssim_d  = neg_q ? -mag : mag;
        fcount_d = dsor_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      cnt_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsor_q   <= '0;
      neg_q    <= 1'b0;
      dcnt_q   <= '0;
      done_q   <= 1'b0;
      fssim_q  <= '0;
      fcount_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsor_q   <= dsor_d;
      neg_q    <= neg_d;
      dcnt_q   <= dcnt_d;
      done_q   <= done_d;
      fssim_q  <= fssim_d;
      fcount_q <= fcount_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.hpix_valid   = pix_valid;
  assign bus.hpix_ssim    = pix_ssim;
  assign bus.hpix_bad     = pix_bad;
  assign bus.hframe_done  = done_q;
  assign bus.hframe_ssim  = fssim_q;
  assign bus.hframe_count = fcount_q;
  assign bus.hoverrun     = ovr_q;

endmodule
